// File: rtl/shift_ctrl_pkg.sv
// shift_ctrl_pkg: shared types and constants for the shift sequencer.
//   state_t   - controller FSM states (IDLE, TX, RX)
//   core_op_t - operation select for the shift_core word register
//   NBITS_DEF - default width of the shared shift word
package shift_ctrl_pkg;

   localparam int NBITS_DEF = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      TX   = 2'd1,
      RX   = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      OP_HOLD = 2'd0,
      OP_LOAD = 2'd1,
      OP_ROT  = 2'd2,   // rotate left, MSB wraps into LSB
      OP_SHIN = 2'd3    // shift left, serial bit enters as LSB
   } core_op_t;

endpackage

// File: rtl/shift_core.sv
// shift_core: the shared NBITS-wide word register.
// Ports:
//   clk_2     - clock, rising edge
//   reset     - asynchronous active-high reset, clears the word
//   op        - core_op_t encoding: hold / load / rotate-left / shift-in
//   load_data - word for OP_LOAD
//   ser_bit   - bit entering the LSB for OP_SHIN
//   word      - current register contents
// NBITS must be at least 2.
module shift_core
   import shift_ctrl_pkg::*;
#(
   parameter int NBITS = NBITS_DEF
) (
   input  logic             clk_2,
   input  logic             reset,
   input  logic [1:0]       op,
   input  logic [NBITS-1:0] load_data,
   input  logic             ser_bit,
   output logic [NBITS-1:0] word
);

   always_ff @(posedge clk_2 or posedge reset) begin
      if (reset) begin
         word <= '0;
      end else begin
         case (core_op_t'(op))
            OP_LOAD: word <= load_data;
            OP_ROT:  word <= {word[NBITS-2:0], word[NBITS-1]};
            OP_SHIN: word <= {word[NBITS-2:0], ser_bit};
            default: word <= word;
         endcase
      end
   end

endmodule

// File: rtl/shift_seq_ctrl.sv
// shift_seq_ctrl: arbitrates between parallel load, serial transmit and
// serial receive of one shared shift word.
// Ports:
//   clk_2, reset           - clock (rising edge), async active-high reset
//   par_req, par_data      - parallel load request and word
//   tx_req                 - request to serialize the stored word, MSB first
//   ser_req, ser_bit       - serial-in bit valid and data
//   gnt_par/gnt_tx/gnt_ser - combinational grants, request taken this edge
//   busy                   - controller is in TX or RX
//   tx_bit, tx_valid       - serial-out data and qualifier
//   word_valid             - one-cycle pulse after a load or a full receive
//   done                   - one-cycle pulse after a full transmit
//   data_out               - current shift word
module shift_seq_ctrl
   import shift_ctrl_pkg::*;
#(
   parameter int NBITS = NBITS_DEF
) (
   input  logic             clk_2,
   input  logic             reset,
   input  logic             par_req,
   input  logic [NBITS-1:0] par_data,
   input  logic             tx_req,
   input  logic             ser_req,
   input  logic             ser_bit,
   output logic             gnt_par,
   output logic             gnt_tx,
   output logic             gnt_ser,
   output logic             busy,
   output logic             tx_bit,
   output logic             tx_valid,
   output logic             word_valid,
   output logic             done,
   output logic [NBITS-1:0] data_out
);

   localparam int CNT_W = $clog2(NBITS) + 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(NBITS - 1);

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   core_op_t         op;
   logic             wv_nxt, done_nxt;
   logic [NBITS-1:0] word;

   shift_core #(.NBITS(NBITS)) u_core (
      .clk_2     (clk_2),
      .reset     (reset),
      .op        (op),
      .load_data (par_data),
      .ser_bit   (ser_bit),
      .word      (word)
   );

   // Fixed priority arbiter, only live in IDLE. Gated by reset so no grant
   // is visible while reset is held even though state already reads IDLE.
   logic idle;
   assign idle    = (state == IDLE) && !reset;
   assign gnt_par = idle && par_req;
   assign gnt_tx  = idle && !par_req && tx_req;
   assign gnt_ser = idle && !par_req && !tx_req && ser_req;

   assign busy     = (state != IDLE);
   assign tx_valid = (state == TX);
   assign tx_bit   = (state == TX) ? word[NBITS-1] : 1'b0;
   assign data_out = word;

   always_ff @(posedge clk_2 or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         cnt        <= '0;
         word_valid <= 1'b0;
         done       <= 1'b0;
      end else begin
         state      <= state_nxt;
         cnt        <= cnt_nxt;
         word_valid <= wv_nxt;
         done       <= done_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      op        = OP_HOLD;
      wv_nxt    = 1'b0;
      done_nxt  = 1'b0;
      case (state)
         IDLE: begin
            if (gnt_par) begin
               op     = OP_LOAD;
               wv_nxt = 1'b1;
            end else if (gnt_tx) begin
               state_nxt = TX;
               cnt_nxt   = '0;
            end else if (gnt_ser) begin
               // The granting edge already captures the first bit.
               op        = OP_SHIN;
               cnt_nxt   = CNT_W'(1);
               state_nxt = RX;
            end
         end
         TX: begin
            // NBITS rotations in total, so the word ends where it started.
            op      = OP_ROT;
            cnt_nxt = cnt + 1'b1;
            if (cnt == LAST) begin
               state_nxt = IDLE;
               done_nxt  = 1'b1;
            end
         end
         RX: begin
            if (ser_req) begin
               op      = OP_SHIN;
               cnt_nxt = cnt + 1'b1;
               if (cnt == LAST) begin
                  state_nxt = IDLE;
                  wv_nxt    = 1'b1;
               end
            end
         end
         default: begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
         end
      endcase
   end

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// tb_shift_seq_ctrl: directed scenario tests for shift_seq_ctrl (NBITS=4).
// Inputs change 1ns after a rising edge; outputs are sampled 1-2ns after it.
module tb_shift_seq_ctrl;

   logic       clk_2 = 1'b0;
   logic       reset;
   logic       par_req, tx_req, ser_req, ser_bit;
   logic [3:0] par_data;
   logic       gnt_par, gnt_tx, gnt_ser, busy, tx_bit, tx_valid, word_valid, done;
   logic [3:0] data_out;

   int n_cmp = 0;
   int n_bad = 0;

   shift_seq_ctrl #(.NBITS(4)) dut (
      .clk_2      (clk_2),
      .reset      (reset),
      .par_req    (par_req),
      .par_data   (par_data),
      .tx_req     (tx_req),
      .ser_req    (ser_req),
      .ser_bit    (ser_bit),
      .gnt_par    (gnt_par),
      .gnt_tx     (gnt_tx),
      .gnt_ser    (gnt_ser),
      .busy       (busy),
      .tx_bit     (tx_bit),
      .tx_valid   (tx_valid),
      .word_valid (word_valid),
      .done       (done),
      .data_out   (data_out)
   );

   always #5 clk_2 = ~clk_2;

   initial begin
      #50000;
      $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk_2);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; par_req = 1'b1; par_data = 4'hF; tx_req = 1'b1; ser_req = 1'b1; ser_bit = 1'b1;
      #1;
      n_cmp++;
      if ({gnt_par, gnt_tx, gnt_ser} !== 3'b000) begin
         $display("FAIL reset_grants: got %b required 000", {gnt_par, gnt_tx, gnt_ser}); n_bad++;
      end
      tick(); tick();
      n_cmp++;
      if ({busy, tx_valid, tx_bit, word_valid, done, data_out} !== 9'b0) begin
         $display("FAIL reset_state: got %b required 000000000",
                  {busy, tx_valid, tx_bit, word_valid, done, data_out}); n_bad++;
      end
      par_req = 1'b0; tx_req = 1'b0; ser_req = 1'b0; ser_bit = 1'b0;
      reset = 1'b0;
   endtask

   // Also covers acceptance on the first edge after reset release.
   task automatic test_par_load();
      par_req = 1'b1; par_data = 4'hA;
      #1;
      n_cmp++;
      if ({gnt_par, gnt_tx, gnt_ser} !== 3'b100) begin
         $display("FAIL par_grant: got %b required 100", {gnt_par, gnt_tx, gnt_ser}); n_bad++;
      end
      tick();
      par_req = 1'b0;
      n_cmp++;
      if ({data_out, word_valid, busy} !== {4'hA, 1'b1, 1'b0}) begin
         $display("FAIL par_load: got data=%h wv=%b busy=%b required data=a wv=1 busy=0",
                  data_out, word_valid, busy); n_bad++;
      end
      tick();
      n_cmp++;
      if ({data_out, word_valid} !== {4'hA, 1'b0}) begin
         $display("FAIL par_wv_pulse: got data=%h wv=%b required data=a wv=0", data_out, word_valid); n_bad++;
      end
   endtask

   task automatic load_word(input logic [3:0] w);
      par_req = 1'b1; par_data = w;
      tick();
      par_req = 1'b0;
      tick();
   endtask

   task automatic test_tx();
      logic [3:0] exp_bits;
      exp_bits = 4'b1011;
      load_word(4'b1011);
      tx_req = 1'b1;
      #1;
      n_cmp++;
      if ({gnt_par, gnt_tx, gnt_ser} !== 3'b010) begin
         $display("FAIL tx_grant: got %b required 010", {gnt_par, gnt_tx, gnt_ser}); n_bad++;
      end
      tick();
      tx_req = 1'b0;
      for (int i = 0; i < 4; i++) begin
         n_cmp++;
         if ({tx_valid, tx_bit, busy, done} !== {1'b1, exp_bits[3-i], 1'b1, 1'b0}) begin
            $display("FAIL tx_bit%0d: got valid=%b bit=%b busy=%b done=%b required valid=1 bit=%b busy=1 done=0",
                     i, tx_valid, tx_bit, busy, done, exp_bits[3-i]); n_bad++;
         end
         tick();
      end
      n_cmp++;
      if ({done, tx_valid, tx_bit, busy, data_out} !== {4'b1000, 4'b1011}) begin
         $display("FAIL tx_done: got done=%b valid=%b bit=%b busy=%b data=%b required done=1 valid=0 bit=0 busy=0 data=1011",
                  done, tx_valid, tx_bit, busy, data_out); n_bad++;
      end
      tick();
      n_cmp++;
      if (done !== 1'b0) begin
         $display("FAIL tx_done_pulse: got done=%b required 0", done); n_bad++;
      end
   endtask

   task automatic test_rx_stall();
      logic [3:0] bits;
      logic [3:0] exp_word [4];
      bits = 4'b1101;                 // bits fed in order 1,1,0,1
      exp_word[0] = 4'b0111;          // starts from 1011
      exp_word[1] = 4'b1111;
      exp_word[2] = 4'b1110;
      exp_word[3] = 4'b1101;
      ser_req = 1'b1; ser_bit = bits[3];
      #1;
      n_cmp++;
      if ({gnt_par, gnt_tx, gnt_ser} !== 3'b001) begin
         $display("FAIL ser_grant: got %b required 001", {gnt_par, gnt_tx, gnt_ser}); n_bad++;
      end
      for (int i = 0; i < 4; i++) begin
         ser_req = 1'b1; ser_bit = bits[3-i];
         tick();
         n_cmp++;
         if ({data_out, busy, word_valid} !== {exp_word[i], (i != 3), (i == 3)}) begin
            $display("FAIL rx_bit%0d: got data=%b busy=%b wv=%b required data=%b busy=%b wv=%b",
                     i, data_out, busy, word_valid, exp_word[i], (i != 3), (i == 3)); n_bad++;
         end
         if (i == 1) begin
            ser_req = 1'b0; ser_bit = 1'b0;
            for (int s = 0; s < 2; s++) begin
               tick();
               n_cmp++;
               if ({data_out, busy, word_valid} !== {4'b1111, 1'b1, 1'b0}) begin
                  $display("FAIL rx_stall%0d: got data=%b busy=%b wv=%b required data=1111 busy=1 wv=0",
                           s, data_out, busy, word_valid); n_bad++;
               end
            end
         end
      end
      ser_req = 1'b0; ser_bit = 1'b0;
      tick();
      n_cmp++;
      if ({data_out, word_valid} !== {4'b1101, 1'b0}) begin
         $display("FAIL rx_wv_pulse: got data=%b wv=%b required data=1101 wv=0", data_out, word_valid); n_bad++;
      end
   endtask

   task automatic test_priority();
      par_req = 1'b1; par_data = 4'h5; tx_req = 1'b1; ser_req = 1'b1; ser_bit = 1'b0;
      #1;
      n_cmp++;
      if ({gnt_par, gnt_tx, gnt_ser} !== 3'b100) begin
         $display("FAIL prio_all: got %b required 100", {gnt_par, gnt_tx, gnt_ser}); n_bad++;
      end
      tick();
      par_req = 1'b0;
      #1;
      n_cmp++;
      if ({gnt_par, gnt_tx, gnt_ser, data_out} !== {3'b010, 4'h5}) begin
         $display("FAIL prio_tx_ser: got gnt=%b data=%h required gnt=010 data=5",
                  {gnt_par, gnt_tx, gnt_ser}, data_out); n_bad++;
      end
      tick();
      tx_req = 1'b0;               // ser_req stays held through TX
      for (int i = 0; i < 4; i++) begin
         n_cmp++;
         if ({gnt_par, gnt_tx, gnt_ser, tx_valid} !== 4'b0001) begin
            $display("FAIL prio_in_tx%0d: got gnt=%b valid=%b required gnt=000 valid=1",
                     i, {gnt_par, gnt_tx, gnt_ser}, tx_valid); n_bad++;
         end
         tick();
      end
      n_cmp++;
      if ({gnt_par, gnt_tx, gnt_ser, done, data_out} !== {3'b001, 1'b1, 4'h5}) begin
         $display("FAIL prio_after_tx: got gnt=%b done=%b data=%h required gnt=001 done=1 data=5",
                  {gnt_par, gnt_tx, gnt_ser}, done, data_out); n_bad++;
      end
      ser_req = 1'b0;              // withdraw before the edge so it is not taken
      tick();
      n_cmp++;
      if ({busy, data_out} !== {1'b0, 4'h5}) begin
         $display("FAIL prio_idle: got busy=%b data=%h required busy=0 data=5", busy, data_out); n_bad++;
      end
   endtask

   task automatic test_reset_mid_tx();
      load_word(4'b1011);
      tx_req = 1'b1;
      tick();
      tx_req = 1'b0;
      tick(); tick();              // two bits shifted out: word now 1110
      n_cmp++;
      if ({tx_valid, tx_bit, data_out} !== {1'b1, 1'b1, 4'b1110}) begin
         $display("FAIL rst_pre: got valid=%b bit=%b data=%b required valid=1 bit=1 data=1110",
                  tx_valid, tx_bit, data_out); n_bad++;
      end
      reset = 1'b1;
      #1;
      n_cmp++;
      if ({data_out, busy, tx_valid, tx_bit, done} !== 8'b0) begin
         $display("FAIL rst_immediate: got data=%b busy=%b valid=%b bit=%b done=%b required all 0",
                  data_out, busy, tx_valid, tx_bit, done); n_bad++;
      end
      tick();
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_cmp++;
         if ({done, busy, tx_valid, data_out} !== 7'b0) begin
            $display("FAIL rst_after%0d: got done=%b busy=%b valid=%b data=%b required all 0",
                     i, done, busy, tx_valid, data_out); n_bad++;
         end
      end
   endtask

   initial begin
      test_reset();
      test_par_load();
      test_tx();
      test_rx_stall();
      test_priority();
      test_reset_mid_tx();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/shift_seq_ctrl.md
SHIFT_SEQ_CTRL -- requirements
Module: shift_seq_ctrl

Interface
REQ-001 SHALL have parameter NBITS, default 4, width of the shared shift word.
REQ-002 SHALL have port clk_2  input  1  sole clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port par_req  input  1  parallel-load request.
REQ-005 SHALL have port par_data  input  NBITS  word to load.
REQ-006 SHALL have port tx_req  input  1  request to serialize the stored word out.
REQ-007 SHALL have port ser_req  input  1  serial-in bit valid.
REQ-008 SHALL have port ser_bit  input  1  serial-in data bit.
REQ-009 SHALL have port gnt_par, gnt_tx, gnt_ser  output  1 each  combinational grant: the request is accepted on this edge.
REQ-010 SHALL have port busy  output  1  high when the state is not IDLE.
REQ-011 SHALL have port tx_bit, tx_valid  output  1 each  serial-out data and qualifier.
REQ-012 SHALL have port word_valid, done  output  1 each  one-cycle pulses.
REQ-013 SHALL have port data_out  output  NBITS  current shift word, for LED display.

Function
REQ-014 FSM states SHALL be IDLE, TX and RX.
REQ-015 In IDLE, arbitration SHALL be fixed priority, par_req > tx_req > ser_req; exactly one grant SHALL be high, and only for the highest active request.
REQ-016 No grant SHALL assert outside IDLE; requests in TX or RX are ignored, and the requester holds its request.
REQ-017 On a par grant: word <= par_data; state stays IDLE; word_valid SHALL pulse on the next cycle.
REQ-018 On a tx grant: state -> TX, cnt <= 0, word unchanged.
REQ-019 In TX: tx_valid=1 and tx_bit=word[NBITS-1]; each edge SHALL rotate word left (MSB into LSB) and increment cnt.
REQ-020 On the edge where cnt==NBITS-1, TX SHALL go to IDLE; done pulses the next cycle; word equals its pre-TX value (exactly NBITS rotations).
REQ-021 On a ser grant: word <= {word[NBITS-2:0], ser_bit}, cnt <= 1, state -> RX.
REQ-022 In RX, each edge with ser_req=1 SHALL shift ser_bit in as LSB and increment cnt; ser_req=0 stalls with word and cnt held.
REQ-023 When the NBITS-th bit is shifted in, RX SHALL go to IDLE; word_valid pulses the next cycle.
REQ-024 Outside TX, tx_valid=0 and tx_bit=0.
REQ-025 cnt width SHALL be $clog2(NBITS)+1; cnt SHALL never exceed NBITS.

Reset
REQ-026 Reset assertion SHALL immediately force state=IDLE, word=0, cnt=0 and deassert all pulses, grants and tx_valid, including mid-TX or mid-RX.
REQ-027 After reset, the first rising edge with reset low SHALL be able to accept a request.

Structure
REQ-028 Package shift_ctrl_pkg SHALL hold the state enum typedef and the NBITS default constant.
REQ-029 Sub-module shift_core SHALL hold the word register with hold, load, rotate-left and shift-in operations; shift_seq_ctrl holds the FSM, counter and arbiter.

Verification
REQ-030 par_req=1, par_data=4'hA in IDLE -> gnt_par=1 that cycle; data_out=4'hA and word_valid=1 the next cycle; busy stays 0.
REQ-031 word=4'b1011, tx_req held -> tx_bit sequence 1,0,1,1 over 4 cycles with tx_valid=1; done pulse; data_out=4'b1011.
REQ-032 ser_req with bits 1,1,0,1 and a 2-cycle ser_req=0 gap after bit 2 -> data_out=4'b1101, word_valid after the 4th bit, no change during the stall.
REQ-033 par_req, tx_req and ser_req all asserted in IDLE -> only gnt_par=1; next cycle tx_req wins; during TX, gnt_ser=0.
REQ-034 reset asserted after 2 TX bits -> data_out=0, busy=0, tx_valid=0 immediately, with no done pulse.
